// File: rtl/aiken_word_conv_if.sv
// Handshake bundle between an Aiken-word source, the converter and a binary consumer.
interface aiken_word_conv_if #(
    parameter int NDIG = 4,
    parameter int OUTW = 14,
    parameter int IDXW = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   in_aiken;
    logic                out_valid;
    logic                out_ready;
    logic [OUTW-1:0]     out_bin;
    logic                out_invalid;
    logic [IDXW-1:0]     out_err_idx;

    modport master (
        output in_valid, in_aiken, out_ready,
        input  in_ready, out_valid, out_bin, out_invalid, out_err_idx
    );

    modport slave (
        input  in_valid, in_aiken, out_ready,
        output in_ready, out_valid, out_bin, out_invalid, out_err_idx
    );
endinterface

// File: rtl/aiken_word_conv.sv
// Serial Aiken (2-4-2-1) word to binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, first (most significant) illegal digit is flagged.
//
// state | meaning
// IDLE  | ready for a new word, outputs cleared
// CONV  | decoding one digit per cycle from the top nibble of the shift register
// DONE  | result held on the output until the consumer takes it
module aiken_word_conv #(
    parameter int NDIG = 4,
    parameter int OUTW = 14,
    parameter int IDXW = 2
) (
    input  logic                clk,
    input  logic                rst,
    aiken_word_conv_if.slave    bus
);
    localparam int W = 4 * NDIG;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [W-1:0]      sreg;
    logic [OUTW-1:0]   acc;
    logic [IDXW-1:0]   cnt;
    logic              err;
    logic [IDXW-1:0]   err_idx;
    logic [OUTW-1:0]   out_bin_r;
    logic              out_inv_r;
    logic [IDXW-1:0]   out_idx_r;

    logic [3:0]        nib;
    logic [3:0]        dig_val;
    logic              dig_bad;
    logic [OUTW-1:0]   acc_nxt;
    logic              err_nxt;
    logic [IDXW-1:0]   err_idx_nxt;
    logic              last;

    assign nib  = sreg[W-1 -: 4];
    assign last = (cnt == '0);

    // Shared digit decoder; illegal codes 0101-1010 contribute zero.
    always_comb begin
        dig_val = 4'd0;
        dig_bad = 1'b0;
        if (nib <= 4'd4) begin
            dig_val = nib;
        end else if (nib >= 4'hB) begin
            dig_val = nib - 4'd6;
        end else begin
            dig_bad = 1'b1;
        end
    end

    // Next accumulator and error tracking; only the first illegal digit records its index.
    always_comb begin
        acc_nxt     = acc * OUTW'(10) + OUTW'(dig_val);
        err_nxt     = err | dig_bad;
        err_idx_nxt = (dig_bad && !err) ? cnt : err_idx;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = CONV;
            CONV:    if (last)         state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, per-digit accumulate/shift, register the result, clear on handoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            err_idx   <= '0;
            out_bin_r <= '0;
            out_inv_r <= 1'b0;
            out_idx_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg    <= bus.in_aiken;
                        acc     <= '0;
                        cnt     <= IDXW'(NDIG - 1);
                        err     <= 1'b0;
                        err_idx <= '0;
                    end
                end
                CONV: begin
                    sreg    <= sreg << 4;
                    acc     <= acc_nxt;
                    err     <= err_nxt;
                    err_idx <= err_idx_nxt;
                    if (!last) begin
                        cnt <= cnt - IDXW'(1);
                    end else begin
                        out_bin_r <= err_nxt ? '0 : acc_nxt;
                        out_inv_r <= err_nxt;
                        out_idx_r <= err_idx_nxt;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_bin_r <= '0;
                        out_inv_r <= 1'b0;
                        out_idx_r <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE) && !rst;
    assign bus.out_valid   = (state == DONE);
    assign bus.out_bin     = out_bin_r;
    assign bus.out_invalid = out_inv_r;
    assign bus.out_err_idx = out_idx_r;
endmodule

// File: tb/tb_aiken_word_conv.sv
// Directed bench for aiken_word_conv with a per-cycle reference model.
module tb_aiken_word_conv;
    localparam int NDIG = 4;
    localparam int OUTW = 14;
    localparam int IDXW = 2;

    logic clk;
    logic rst;

    aiken_word_conv_if #(.NDIG(NDIG), .OUTW(OUTW), .IDXW(IDXW)) bus ();

    aiken_word_conv #(.NDIG(NDIG), .OUTW(OUTW), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Aiken code -> decimal value, -1 for illegal codes
    int aval [16] = '{0, 1, 2, 3, 4, -1, -1, -1, -1, -1, -1, 5, 6, 7, 8, 9};

    // model state
    bit m_idle  = 1;
    int m_left  = 0;
    bit m_valid = 0;
    int m_bin   = 0;
    bit m_inv   = 0;
    int m_idx   = 0;
    int p_bin;
    bit p_inv;
    int p_idx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void conv(input logic [4*NDIG-1:0] w, output int bin, output bit inv, output int idx);
        int d;
        bin = 0;
        inv = 0;
        idx = 0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            d = aval[int'((w >> (4 * k)) & 'hF)];
            if (d < 0) begin
                if (!inv) idx = k;
                inv = 1;
                d = 0;
            end
            bin = (bin * 10 + d) % (1 << OUTW);
        end
        if (inv) bin = 0;
    endfunction

    // Per-cycle compare against the model, then advance the model to the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_idle = 1; m_left = 0; m_valid = 0; m_bin = 0; m_inv = 0; m_idx = 0;
            end
            check("mdl_in_ready",  bus.in_ready,    (m_idle && !rst) ? 1 : 0);
            check("mdl_out_valid", bus.out_valid,   m_valid);
            check("mdl_out_bin",   bus.out_bin,     m_bin);
            check("mdl_out_inv",   bus.out_invalid, m_inv);
            check("mdl_err_idx",   bus.out_err_idx, m_idx);
            if (!rst) begin
                if (m_idle && bus.in_valid) begin
                    conv(bus.in_aiken, p_bin, p_inv, p_idx);
                    m_idle = 0;
                    m_left = NDIG;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_valid = 1; m_bin = p_bin; m_inv = p_inv; m_idx = p_idx;
                    end
                end else if (m_valid && bus.out_ready) begin
                    m_valid = 0; m_bin = 0; m_inv = 0; m_idx = 0; m_idle = 1;
                end
            end
        end
    end

    task automatic send(input logic [15:0] w);
        bit ok;
        bit rdy;
        ok = 0;
        bus.in_aiken = w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) check("result_timeout", 0, 1);
    endtask

    task automatic run_word(input logic [15:0] w, input int eb, input int ei, input int ex);
        int lat;
        send(w);
        wait_result(lat);
        check("latency", lat, 4);
        check("lit_out_bin", bus.out_bin, eb);
        check("lit_out_inv", bus.out_invalid, ei);
        check("lit_err_idx", bus.out_err_idx, ex);
        @(posedge clk);
        #1;
        check("back_idle_ready", bus.in_ready, 1);
        check("back_idle_valid", bus.out_valid, 0);
    endtask

    initial begin
        int lat;
        int b;
        bit iv;
        int ix;

        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_aiken  = '0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready",  bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bin",   bus.out_bin, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // pin the model with hand-computed values
        conv(16'h1534, b, iv, ix);
        check("model_1534_bin", b, 0);
        check("model_1534_inv", iv, 1);
        check("model_1534_idx", ix, 2);
        conv(16'hFEDB, b, iv, ix);
        check("model_FEDB_bin", b, 9875);
        conv(16'h5671, b, iv, ix);
        check("model_5671_idx", ix, 3);

        @(posedge clk);
        #1;
        run_word(16'h1234, 1234, 0, 0);
        run_word(16'hFEDB, 9875, 0, 0);
        run_word(16'h0000, 0, 0, 0);
        run_word(16'hFFFF, 9999, 0, 0);
        run_word(16'h1534, 0, 1, 2);
        run_word(16'h5671, 0, 1, 3);
        run_word(16'h0B04, 504, 0, 0);

        // back-pressure, with a second word waiting
        bus.out_ready = 1'b0;
        send(16'h0312);
        wait_result(lat);
        check("bp_latency", lat, 4);
        check("bp_bin", bus.out_bin, 312);
        bus.in_aiken = 16'h0004;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_bin",   bus.out_bin, 312);
            check("bp_hold_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", bus.out_valid, 0);
        check("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        check("bp_second_accepted", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        wait_result(lat);
        check("bp_second_latency", lat, 4);
        check("bp_second_bin", bus.out_bin, 4);
        @(posedge clk);
        #1;

        // input change during conversion is ignored
        send(16'h0001);
        @(posedge clk);
        #1;
        bus.in_aiken = 16'hFFFF;
        wait_result(lat);
        check("chg_bin", bus.out_bin, 1);
        check("chg_inv", bus.out_invalid, 0);
        @(posedge clk);
        #1;

        // reset in the middle of a conversion
        send(16'h1234);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_in_ready",  bus.in_ready, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_out_bin",   bus.out_bin, 0);
        check("arst_out_inv",   bus.out_invalid, 0);
        check("arst_err_idx",   bus.out_err_idx, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_post_ready", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("arst_no_valid", bus.out_valid, 0);
        end
        run_word(16'h0004, 4, 0, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/aiken_word_conv.md
Name: aiken_word_conv

Overview:
Sequential controller that accepts a packed multi-digit Aiken (2-4-2-1) coded decimal word and converts it to a single binary integer. It uses one shared Aiken-digit decoder, processing one digit per clock from the most significant digit down, and accumulates acc = acc*10 + digit. It sits between a valid/ready Aiken source and a binary consumer. It flags the first illegal digit code it finds.

Parameters:
NDIG, 4, number of Aiken digits per input word (1..8)
OUTW, 14, binary result width; must be >= ceil(log2(10^NDIG)); 14 covers 9999
IDXW, 2, error-index width; must be >= max(1, ceil(log2(NDIG)))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  source presents a word
in_ready  out  1  block can accept a word
in_aiken  in  4*NDIG  packed Aiken digits; digit k = bits [4k+3:4k], k=0 is least significant
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_bin  out  OUTW  binary value of the word
out_invalid  out  1  at least one digit code was illegal
out_err_idx  out  IDXW  index k of the most significant illegal digit; 0 when out_invalid=0

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. In reset: state=IDLE, in_ready=0 while rst is high, out_valid=0, out_bin=0, out_invalid=0, out_err_idx=0. Internal shift register, accumulator and digit counter are cleared.
- Digit decode: 0000-0100 -> 0-4; 1011-1111 -> 5-9; 0101-1010 are illegal and contribute 0 to the accumulator.
- FSM states: IDLE, CONV, DONE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - Capture in_aiken into the shift register.
  - Set acc=0, cnt=NDIG-1, err=0, err_idx=0.
  - Go to CONV.
- CONV: in_ready=0. Each cycle:
  - Decode the top nibble of the shift register, which is digit cnt.
  - acc <= acc*10 + value, computed at OUTW bits and wrapping modulo 2^OUTW.
  - If the nibble is illegal and err=0: err<=1 and err_idx<=cnt. Later illegal digits do not overwrite err_idx.
  - Shift the register left by 4 and decrement cnt.
  - On the cycle that processes cnt=0, go to DONE and register the outputs.
- Latency: out_valid rises exactly NDIG clock edges after the accepting edge (4 for the default).
- DONE: out_valid=1, in_ready=0.
  - out_bin = err ? 0 : acc.
  - out_invalid = err, out_err_idx = err_idx.
  - All outputs stay stable until out_ready is sampled high. On out_valid & out_ready go to IDLE and clear out_valid, out_bin, out_invalid and out_err_idx.
  - No overlap between words: peak throughput is one word per NDIG+2 cycles.
- in_aiken is sampled only on the accepting edge. Changes afterwards do not affect the conversion in flight.
- in_valid high during CONV or DONE is ignored. The source holds the word until in_ready.
- out_ready high while out_valid=0 has no effect.
- Reset mid-CONV or mid-DONE: the word is discarded, no out_valid is produced, and the FSM is in IDLE on the first edge after rst deasserts. in_ready=1 from that point.
- NDIG=1: CONV lasts exactly one cycle.

Test Plan:
- in_aiken=16'h1234 (digits 1,2,3,4), out_ready=1 -> accepted on edge E0; out_valid at E4 with out_bin=1234 (0x4D2), out_invalid=0, out_err_idx=0; back in IDLE with in_ready=1 at E5.
- in_aiken=16'hFEDB (9,8,7,5) -> out_bin=9875, out_invalid=0; in_aiken=16'h0000 -> out_bin=0, out_invalid=0; in_aiken=16'hFFFF -> out_bin=9999.
- in_aiken=16'h1534 (digit 2 = 0101 illegal) -> out_invalid=1, out_err_idx=2, out_bin=0. in_aiken=16'h5671 (digits 3, 2, 1 illegal) -> out_err_idx=3.
- Back-pressure: 16'h0312 converted with out_ready=0 for 6 cycles after out_valid -> out_bin=312 held stable and in_ready=0 throughout; a second word on in_valid is not accepted until one cycle after out_ready=1.
- rst pulsed two cycles after accepting 16'h1234 -> all outputs 0 immediately (asynchronously); out_valid never asserts; in_ready=1 on the first edge after release; a new word 16'h0004 then yields 4.
- Input changes during CONV: in_aiken switched to 16'hFFFF one cycle after accepting 16'h0001 -> result is still 1.
